pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised program-counter unit for the CPU fetch stage. Replaces the fixed 5-bit increment/load counter.
- Adds a registered PC output, a stall control, signed relative branches, and absolute jumps.
- Adds a hardware return-address stack for call and return, with sticky overflow and underflow error flags.
- Sits between the control unit, which issues the commands, and instruction memory, which the pc output addresses.

Parameters:
- ADDR_W, 5, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- OFF_W, 5, width of the signed branch offset; must be <= ADDR_W.
- STEP, 1, increment applied on normal advance and used for the call return address.
- RESET_VEC, 0, PC value after reset.
- STACK_DEPTH, 4, number of return-address entries; must be >= 1.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- stall, in, 1, freezes all state for the cycle when high.
- load, in, 1, absolute jump to data_in.
- branch, in, 1, relative jump: pc + sign-extended offset.
- call, in, 1, push pc+STEP and jump to data_in.
- ret, in, 1, pop the stack top into pc.
- data_in, in, ADDR_W, target address for load and call.
- offset, in, OFF_W, signed two's-complement branch offset.
- pc_count, out, ADDR_W, current PC; driven directly from a register.
- stack_empty, out, 1, high when the stack holds 0 entries.
- stack_full, out, 1, high when the stack holds STACK_DEPTH entries.
- ovf_err, out, 1, sticky flag: call was issued while the stack was full.
- unf_err, out, 1, sticky flag: ret was issued while the stack was empty.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: pc_count=RESET_VEC, stack pointer=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0.
  - Stack entry contents are don't-care after reset.
  - Reset asserted mid-operation aborts any command immediately. The first edge after release behaves normally.
- Update rule: commands are sampled at each rising edge and the new PC is visible after that same edge (one-edge latency). There is no combinational path from inputs to pc_count.
- stall=1: pc_count, the stack, and both error flags all hold, regardless of the other inputs.
- Priority when stall=0, highest first: ret, call, load, branch, default increment.
  - ret, stack not empty: pc <= stack[top]; sp decrements.
  - ret, stack empty: unf_err <= 1; pc <= pc+STEP (treated as a NOP advance).
  - call, stack not full: stack[sp] <= pc+STEP; sp increments; pc <= data_in.
  - call, stack full: ovf_err <= 1; no push, no jump; pc <= pc+STEP.
  - load: pc <= data_in.
  - branch: pc <= pc + sign_extend(offset, ADDR_W).
  - none of the above: pc <= pc + STEP.
- Arithmetic: all sums truncate to ADDR_W bits and wrap silently. With ADDR_W=5, PC 31 +1 gives 0, and PC 1 + offset -3 gives 30.
- Stack pointer ranges 0..STACK_DEPTH; stack_full = (sp == STACK_DEPTH).
- Simultaneous lower-priority commands are ignored in the cycle they are overridden; the block does not queue them.
- Error flags clear only on reset.

Test Plan:
1. Reset and increment. rst_n=0 mid-count, then release with no commands. pc_count=0 immediately on assertion; after release it reads 1, 2, 3 on successive edges; 31 is followed by 0.
2. Load and branch. Load data_in=20 gives 20. Branch offset=+5 (5'b00101) gives 25. Branch offset=-3 (5'b11101) gives 22. Branch +15 from 22 gives 5 (wrap).
3. Call and return nesting. From pc=3: call 10 gives 10; call 16 gives 16; ret gives 11; ret gives 4. stack_empty=1 at the end and both error flags are 0.
4. Overflow and underflow. Issue five calls with STACK_DEPTH=4: the fifth sets ovf_err=1, keeps sp=4, and pc only advances by 1. Four rets then empty the stack. A fifth ret sets unf_err=1 and pc advances by 1.
5. Priority and stall. Assert ret, call, load, and branch together: only the ret pop occurs. Then assert stall=1 together with load=1, data_in=7: pc and sp are unchanged for that cycle.
6. Reset mid-call. Pulse rst_n low asynchronously with no clock edge, while call=1 and the stack is non-empty. Outputs return to RESET_VEC, sp returns to 0, and the flags clear without waiting for a clock edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative/absolute jumps and a hardware
// return-address stack for call/ret, with sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int ADDR_W      = 5,
  parameter int OFF_W       = 5,
  parameter int STEP        = 1,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              load,
  input  logic              branch,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] pc_count,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
  localparam logic [SP_W-1:0]   SP_MAX = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]   SP_ONE = SP_W'(1);

  logic [ADDR_W-1:0]                   pc_q, pc_d, pc_inc, off_ext;
  logic [SP_W-1:0]                     sp_q, sp_d, top_sp;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0]  stk_q, stk_d;
  logic                                ovf_q, ovf_d, unf_q, unf_d;
  logic [IDX_W-1:0]                    top_idx, push_idx;
  logic                                empty, full;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_MAX);
  assign pc_inc   = pc_q + STEP_V;
  // size cast of a signed value sign-extends the offset to PC width
  assign off_ext  = ADDR_W'($signed(offset));
  assign top_sp   = sp_q - SP_ONE;
  assign top_idx  = top_sp[IDX_W-1:0];
  assign push_idx = sp_q[IDX_W-1:0];

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    stk_d = stk_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!stall) begin
      if (ret) begin
        if (!empty) begin
          pc_d = stk_q[top_idx];
          sp_d = top_sp;
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (call) begin
        // a call on a full stack degrades to a plain advance
        if (!full) begin
          stk_d[push_idx] = pc_inc;
          sp_d            = sp_q + SP_ONE;
          pc_d            = data_in;
        end else begin
          ovf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (load) begin
        pc_d = data_in;
      end else if (branch) begin
        pc_d = pc_q + off_ext;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RST_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // entry contents are meaningless until pushed, so no reset is needed
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign pc_count    = pc_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: expected outputs are queued as each
// command is driven and popped for comparison one edge later.
module tb_pc_stack_unit;

  logic       clk, rst_n;
  logic       stall, load, branch, call, ret;
  logic [4:0] data_in, offset;
  logic [4:0] pc_count;
  logic       stack_empty, stack_full, ovf_err, unf_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic s, r, c, l, b;
    logic [4:0] d, off;
  } cmd_t;

  typedef struct packed {
    logic [4:0] pc;
    logic empty, full, ovf, unf;
  } obs_t;

  obs_t sb[$];

  pc_stack_unit #(.ADDR_W(5), .OFF_W(5), .STEP(1), .RESET_VEC(0), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .load(load), .branch(branch),
    .call(call), .ret(ret), .data_in(data_in), .offset(offset),
    .pc_count(pc_count), .stack_empty(stack_empty), .stack_full(stack_full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cmd_t C(input logic s, r, c, l, b, input logic [4:0] d, off);
    cmd_t x;
    x.s = s; x.r = r; x.c = c; x.l = l; x.b = b; x.d = d; x.off = off;
    return x;
  endfunction

  function automatic obs_t E(input logic [4:0] pc, input logic e, f, o, u);
    obs_t x;
    x.pc = pc; x.empty = e; x.full = f; x.ovf = o; x.unf = u;
    return x;
  endfunction

  function automatic obs_t obs();
    obs_t x;
    x = {pc_count, stack_empty, stack_full, ovf_err, unf_err};
    return x;
  endfunction

  task automatic set_in(input cmd_t c);
    stall = c.s; ret = c.r; call = c.c; load = c.l; branch = c.b;
    data_in = c.d; offset = c.off;
  endtask

  // drive one command, queue its expected result, advance past the edge
  task automatic drive(input cmd_t c, input obs_t e);
    set_in(c);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam cmd_t IDLE = '0;

  task automatic test_reset();
    obs_t got, exp;
    obs_t ev[3];
    rst_n = 1'b0;
    set_in(IDLE);
    #2;
    sb.push_back(E(5'd0, 1, 0, 0, 0));
    got = obs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_init: got pc=%0d efou=%b want pc=%0d efou=%b",
               got.pc, got[3:0], exp.pc, exp[3:0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ev[0] = E(5'd1, 1, 0, 0, 0); ev[1] = E(5'd2, 1, 0, 0, 0); ev[2] = E(5'd3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(IDLE, ev[i]);
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL inc[%0d]: got pc=%0d efou=%b want pc=%0d efou=%b",
                 i, got.pc, got[3:0], exp.pc, exp[3:0]);
      end
    end
    // asynchronous assertion mid-count, checked between edges
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(E(5'd0, 1, 0, 0, 0));
    got = obs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_async: got pc=%0d efou=%b want pc=%0d efou=%b",
               got.pc, got[3:0], exp.pc, exp[3:0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(IDLE, ev[i]);
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL inc_after_reset[%0d]: got pc=%0d efou=%b want pc=%0d efou=%b",
                 i, got.pc, got[3:0], exp.pc, exp[3:0]);
      end
    end
    // wrap 31 -> 0
    drive(C(0, 0, 0, 1, 0, 5'd30, 5'd0), E(5'd30, 1, 0, 0, 0));
    drive(IDLE, E(5'd31, 1, 0, 0, 0));
    drive(IDLE, E(5'd0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      exp = sb.pop_front(); n_cmp++;
      if (i == 2) begin
        got = obs();
        if (got !== exp) begin
          n_err++;
          $display("FAIL wrap_inc: got pc=%0d efou=%b want pc=%0d efou=%b",
                   got.pc, got[3:0], exp.pc, exp[3:0]);
        end
      end else n_cmp--;
    end
  endtask

  task automatic test_load_branch();
    cmd_t cv[6];
    obs_t ev[6];
    obs_t got, exp;
    cv[0] = C(0, 0, 0, 1, 0, 5'd20, 5'd0);      ev[0] = E(5'd20, 1, 0, 0, 0);
    cv[1] = C(0, 0, 0, 0, 1, 5'd0, 5'b00101);   ev[1] = E(5'd25, 1, 0, 0, 0);
    cv[2] = C(0, 0, 0, 0, 1, 5'd0, 5'b11101);   ev[2] = E(5'd22, 1, 0, 0, 0);
    cv[3] = C(0, 0, 0, 0, 1, 5'd0, 5'd15);      ev[3] = E(5'd5, 1, 0, 0, 0);
    cv[4] = C(0, 0, 0, 1, 0, 5'd1, 5'd0);       ev[4] = E(5'd1, 1, 0, 0, 0);
    cv[5] = C(0, 0, 0, 0, 1, 5'd0, 5'b11101);   ev[5] = E(5'd30, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(cv[i], ev[i]);
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL load_branch[%0d]: got pc=%0d efou=%b want pc=%0d efou=%b",
                 i, got.pc, got[3:0], exp.pc, exp[3:0]);
      end
    end
  endtask

  task automatic test_call_ret();
    cmd_t cv[5];
    obs_t ev[5];
    obs_t got, exp;
    cv[0] = C(0, 0, 0, 1, 0, 5'd3, 5'd0);   ev[0] = E(5'd3, 1, 0, 0, 0);
    cv[1] = C(0, 0, 1, 0, 0, 5'd10, 5'd0);  ev[1] = E(5'd10, 0, 0, 0, 0);
    cv[2] = C(0, 0, 1, 0, 0, 5'd16, 5'd0);  ev[2] = E(5'd16, 0, 0, 0, 0);
    cv[3] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);   ev[3] = E(5'd11, 0, 0, 0, 0);
    cv[4] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);   ev[4] = E(5'd4, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(cv[i], ev[i]);
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL call_ret[%0d]: got pc=%0d efou=%b want pc=%0d efou=%b",
                 i, got.pc, got[3:0], exp.pc, exp[3:0]);
      end
    end
  endtask

  task automatic test_ovf_unf();
    cmd_t cv[10];
    obs_t ev[10];
    obs_t got, exp;
    // starts at pc=4 with an empty stack
    cv[0] = C(0, 0, 1, 0, 0, 5'd10, 5'd0); ev[0] = E(5'd10, 0, 0, 0, 0);
    cv[1] = C(0, 0, 1, 0, 0, 5'd12, 5'd0); ev[1] = E(5'd12, 0, 0, 0, 0);
    cv[2] = C(0, 0, 1, 0, 0, 5'd14, 5'd0); ev[2] = E(5'd14, 0, 0, 0, 0);
    cv[3] = C(0, 0, 1, 0, 0, 5'd16, 5'd0); ev[3] = E(5'd16, 0, 1, 0, 0);
    cv[4] = C(0, 0, 1, 0, 0, 5'd20, 5'd0); ev[4] = E(5'd17, 0, 1, 1, 0);
    cv[5] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);  ev[5] = E(5'd15, 0, 0, 1, 0);
    cv[6] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);  ev[6] = E(5'd13, 0, 0, 1, 0);
    cv[7] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);  ev[7] = E(5'd11, 0, 0, 1, 0);
    cv[8] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);  ev[8] = E(5'd5, 1, 0, 1, 0);
    cv[9] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);  ev[9] = E(5'd6, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      drive(cv[i], ev[i]);
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ovf_unf[%0d]: got pc=%0d efou=%b want pc=%0d efou=%b",
                 i, got.pc, got[3:0], exp.pc, exp[3:0]);
      end
    end
  endtask

  task automatic test_priority_stall();
    cmd_t cv[8];
    obs_t ev[8];
    obs_t got, exp;
    // from pc=6, both sticky flags already set
    cv[0] = C(0, 0, 1, 0, 0, 5'd25, 5'd0);  ev[0] = E(5'd25, 0, 0, 1, 1);
    cv[1] = C(0, 1, 1, 1, 1, 5'd3, 5'd2);   ev[1] = E(5'd7, 1, 0, 1, 1);
    cv[2] = C(0, 0, 1, 1, 1, 5'd12, 5'd2);  ev[2] = E(5'd12, 0, 0, 1, 1);
    cv[3] = C(0, 0, 0, 1, 1, 5'd20, 5'd5);  ev[3] = E(5'd20, 0, 0, 1, 1);
    cv[4] = C(1, 0, 0, 1, 0, 5'd7, 5'd0);   ev[4] = E(5'd20, 0, 0, 1, 1);
    cv[5] = C(1, 1, 0, 0, 0, 5'd0, 5'd0);   ev[5] = E(5'd20, 0, 0, 1, 1);
    cv[6] = C(1, 0, 1, 0, 0, 5'd29, 5'd0);  ev[6] = E(5'd20, 0, 0, 1, 1);
    cv[7] = C(0, 1, 0, 0, 0, 5'd0, 5'd0);   ev[7] = E(5'd8, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      drive(cv[i], ev[i]);
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL prio_stall[%0d]: got pc=%0d efou=%b want pc=%0d efou=%b",
                 i, got.pc, got[3:0], exp.pc, exp[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid_call();
    obs_t got, exp;
    drive(C(0, 0, 1, 0, 0, 5'd9, 5'd0), E(5'd9, 0, 0, 1, 1));
    got = obs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rmc_push: got pc=%0d efou=%b want pc=%0d efou=%b",
               got.pc, got[3:0], exp.pc, exp[3:0]);
    end
    set_in(C(0, 0, 1, 0, 0, 5'd15, 5'd0));
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(E(5'd0, 1, 0, 0, 0));
    got = obs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rmc_async: got pc=%0d efou=%b want pc=%0d efou=%b",
               got.pc, got[3:0], exp.pc, exp[3:0]);
    end
    #1 rst_n = 1'b1;
    // call still held: first edge after release pushes 1 and jumps
    sb.push_back(E(5'd15, 0, 0, 0, 0));
    @(posedge clk); #1;
    got = obs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rmc_first_edge: got pc=%0d efou=%b want pc=%0d efou=%b",
               got.pc, got[3:0], exp.pc, exp[3:0]);
    end
    drive(C(0, 1, 0, 0, 0, 5'd0, 5'd0), E(5'd1, 1, 0, 0, 0));
    got = obs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rmc_ret: got pc=%0d efou=%b want pc=%0d efou=%b",
               got.pc, got[3:0], exp.pc, exp[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_load_branch();
    test_call_ret();
    test_ovf_unf();
    test_priority_stall();
    test_reset_mid_call();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
